// File: rtl/warp_pc_file.sv
// Per-warp program-counter store for the instruction fetch stage.
// Each warp has one PC and one valid bit. A PC advances by PC_STEP when either
// fetch slot grants that warp, and it is redirected by init, branch or replay.
// Exit only clears the valid bit. Fetch_Req is the request mask seen by the
// fetch arbiter.
module warp_pc_file #(
  parameter int NUM_WARPS = 8,
  parameter int PC_W      = 32,
  parameter int PC_STEP   = 4,
  localparam int WID_W    = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Init_Wen,
  input  logic [WID_W-1:0]     Init_WarpID,
  input  logic [PC_W-1:0]      Init_PC,
  input  logic                 Exit_Wen,
  input  logic [WID_W-1:0]     Exit_WarpID,
  input  logic                 Br_Wen,
  input  logic [WID_W-1:0]     Br_WarpID,
  input  logic [PC_W-1:0]      Br_Target,
  input  logic                 Replay_Wen,
  input  logic [WID_W-1:0]     Replay_WarpID,
  input  logic [PC_W-1:0]      Replay_PC,
  input  logic [NUM_WARPS-1:0] GRT_raw_1_RR_IF,
  input  logic [NUM_WARPS-1:0] GRT_raw_2_RR_IF,
  input  logic [NUM_WARPS-1:0] IB_Full,
  output logic [PC_W-1:0]      PC0_PC_IF,
  output logic [PC_W-1:0]      PC1_PC_IF,
  output logic [PC_W-1:0]      PC2_PC_IF,
  output logic [PC_W-1:0]      PC3_PC_IF,
  output logic [PC_W-1:0]      PC4_PC_IF,
  output logic [PC_W-1:0]      PC5_PC_IF,
  output logic [PC_W-1:0]      PC6_PC_IF,
  output logic [PC_W-1:0]      PC7_PC_IF,
  output logic [NUM_WARPS-1:0] PC_Valid,
  output logic [NUM_WARPS-1:0] Fetch_Req,
  output logic                 Err_Grant
);

  // Instructions are word aligned, so every loaded PC drops its two low bits.
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  logic [PC_W-1:0]      pc_q [NUM_WARPS];
  logic [PC_W-1:0]      pc_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] valid_q, valid_d;
  logic                 err_q, err_d;

  logic                 g1_multi, g2_multi, g_dual;
  logic [NUM_WARPS-1:0] granted;

  // Grant legality: a vector with more than one bit set is dropped entirely.
  // The same warp on both slots still counts as a single grant.
  always_comb begin
    g1_multi = |(GRT_raw_1_RR_IF & (GRT_raw_1_RR_IF - NUM_WARPS'(1)));
    g2_multi = |(GRT_raw_2_RR_IF & (GRT_raw_2_RR_IF - NUM_WARPS'(1)));
    g_dual   = !g1_multi && !g2_multi && |(GRT_raw_1_RR_IF & GRT_raw_2_RR_IF);
    granted  = (g1_multi ? '0 : GRT_raw_1_RR_IF) | (g2_multi ? '0 : GRT_raw_2_RR_IF);
    err_d    = g1_multi || g2_multi || g_dual;
  end

  // Per-warp next state. The priority is init, exit, branch, replay, grant.
  // Only init and exit act on an inactive warp.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      // NOTE: hold values are assigned first so no path leaves pc_d/valid_d unassigned (no latch).
      pc_d[w]    = pc_q[w];
      valid_d[w] = valid_q[w];
      if (Init_Wen && Init_WarpID == WID_W'(w)) begin
        pc_d[w]    = Init_PC & ALIGN_MASK;
        valid_d[w] = 1'b1;
      end else if (Exit_Wen && Exit_WarpID == WID_W'(w)) begin
        valid_d[w] = 1'b0;
      end else if (valid_q[w]) begin
        if (Br_Wen && Br_WarpID == WID_W'(w)) begin
          pc_d[w] = Br_Target & ALIGN_MASK;
        end else if (Replay_Wen && Replay_WarpID == WID_W'(w)) begin
          pc_d[w] = Replay_PC & ALIGN_MASK;
        end else if (granted[w]) begin
          pc_d[w] = pc_q[w] + PC_W'(PC_STEP);
        end
      end
    end
  end

  // State registers. The synchronous reset takes precedence over every event.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the PC store is built from individual flops, not RAM, so every entry is reset.
      for (int w = 0; w < NUM_WARPS; w++) pc_q[w] <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state samples pre-edge values.
      pc_q    <= pc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign PC0_PC_IF = pc_q[0];
  assign PC1_PC_IF = pc_q[1];
  assign PC2_PC_IF = pc_q[2];
  assign PC3_PC_IF = pc_q[3];
  assign PC4_PC_IF = pc_q[4];
  assign PC5_PC_IF = pc_q[5];
  assign PC6_PC_IF = pc_q[6];
  assign PC7_PC_IF = pc_q[7];
  assign PC_Valid  = valid_q;
  assign Fetch_Req = valid_q & ~IB_Full;
  assign Err_Grant = err_q;

endmodule

// File: tb/tb_warp_pc_file.sv
// Directed bench for warp_pc_file. A table of stimulus and expected-value
// records is applied one clock per record. Reset has its own hand-written
// sequences.
module tb_warp_pc_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        Init_Wen, Exit_Wen, Br_Wen, Replay_Wen;
  logic [2:0]  Init_WarpID, Exit_WarpID, Br_WarpID, Replay_WarpID;
  logic [31:0] Init_PC, Br_Target, Replay_PC;
  logic [7:0]  GRT_raw_1_RR_IF, GRT_raw_2_RR_IF, IB_Full;
  logic [31:0] PC0_PC_IF, PC1_PC_IF, PC2_PC_IF, PC3_PC_IF;
  logic [31:0] PC4_PC_IF, PC5_PC_IF, PC6_PC_IF, PC7_PC_IF;
  logic [7:0]  PC_Valid, Fetch_Req;
  logic        Err_Grant;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  warp_pc_file dut (
    .clk(clk), .rst(rst),
    .Init_Wen(Init_Wen), .Init_WarpID(Init_WarpID), .Init_PC(Init_PC),
    .Exit_Wen(Exit_Wen), .Exit_WarpID(Exit_WarpID),
    .Br_Wen(Br_Wen), .Br_WarpID(Br_WarpID), .Br_Target(Br_Target),
    .Replay_Wen(Replay_Wen), .Replay_WarpID(Replay_WarpID), .Replay_PC(Replay_PC),
    .GRT_raw_1_RR_IF(GRT_raw_1_RR_IF), .GRT_raw_2_RR_IF(GRT_raw_2_RR_IF),
    .IB_Full(IB_Full),
    .PC0_PC_IF(PC0_PC_IF), .PC1_PC_IF(PC1_PC_IF), .PC2_PC_IF(PC2_PC_IF),
    .PC3_PC_IF(PC3_PC_IF), .PC4_PC_IF(PC4_PC_IF), .PC5_PC_IF(PC5_PC_IF),
    .PC6_PC_IF(PC6_PC_IF), .PC7_PC_IF(PC7_PC_IF),
    .PC_Valid(PC_Valid), .Fetch_Req(Fetch_Req), .Err_Grant(Err_Grant)
  );

  typedef struct {
    logic        rst;
    logic        iw;  logic [2:0] iid; logic [31:0] ipc;
    logic        ew;  logic [2:0] eid;
    logic        bw;  logic [2:0] bid; logic [31:0] bt;
    logic        rw;  logic [2:0] rid; logic [31:0] rpc;
    logic [7:0]  g1, g2, ibf;
    int          cw;                     // warp whose PC is checked
    logic [31:0] epc;
    logic [7:0]  ev, efr;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(
    input logic iw, input logic [2:0] iid, input logic [31:0] ipc,
    input logic ew, input logic [2:0] eid,
    input logic bw, input logic [2:0] bid, input logic [31:0] bt,
    input logic rw, input logic [2:0] rid, input logic [31:0] rpc,
    input logic [7:0] g1, input logic [7:0] g2, input logic [7:0] ibf,
    input int cw, input logic [31:0] epc, input logic [7:0] ev,
    input logic [7:0] efr, input logic eerr);
    vec_t v;
    v.rst = 1'b0;
    v.iw = iw; v.iid = iid; v.ipc = ipc;
    v.ew = ew; v.eid = eid;
    v.bw = bw; v.bid = bid; v.bt = bt;
    v.rw = rw; v.rid = rid; v.rpc = rpc;
    v.g1 = g1; v.g2 = g2; v.ibf = ibf;
    v.cw = cw; v.epc = epc; v.ev = ev; v.efr = efr; v.eerr = eerr;
    return v;
  endfunction

  function automatic logic [31:0] pc_of(input int w);
    case (w)
      0: return PC0_PC_IF;
      1: return PC1_PC_IF;
      2: return PC2_PC_IF;
      3: return PC3_PC_IF;
      4: return PC4_PC_IF;
      5: return PC5_PC_IF;
      6: return PC6_PC_IF;
      default: return PC7_PC_IF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    Init_Wen = v.iw; Init_WarpID = v.iid; Init_PC = v.ipc;
    Exit_Wen = v.ew; Exit_WarpID = v.eid;
    Br_Wen = v.bw; Br_WarpID = v.bid; Br_Target = v.bt;
    Replay_Wen = v.rw; Replay_WarpID = v.rid; Replay_PC = v.rpc;
    GRT_raw_1_RR_IF = v.g1; GRT_raw_2_RR_IF = v.g2; IB_Full = v.ibf;
  endtask

  task automatic check_all_reset(input string tag);
    for (int w = 0; w < 8; w++) check($sformatf("%s_pc%0d", tag, w), pc_of(w), 32'h0);
    check({tag, "_valid"}, {24'h0, PC_Valid}, 32'h0);
    check({tag, "_freq"},  {24'h0, Fetch_Req}, 32'h0);
    check({tag, "_err"},   {31'h0, Err_Grant}, 32'h0);
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    // Columns: iw iid ipc | ew eid | bw bid bt | rw rid rpc | g1 g2 ibf | cw epc ev efr eerr
    tbl.push_back(mk(1,3,32'h100,      0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 3,32'h100,      8'h08,8'h08,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h08,8'h00,8'h00, 3,32'h104,      8'h08,8'h08,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h08,8'h00,8'h00, 3,32'h108,      8'h08,8'h08,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h08,8'h00,8'h08, 3,32'h10C,      8'h08,8'h00,0));
    tbl.push_back(mk(1,0,32'h1000,     0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 0,32'h1000,     8'h09,8'h09,0));
    tbl.push_back(mk(1,5,32'h2003,     0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 5,32'h2000,     8'h29,8'h29,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h01,8'h20,8'h01, 0,32'h1004,     8'h29,8'h28,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 5,32'h2004,     8'h29,8'h29,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h01,8'h01,8'h00, 0,32'h1008,     8'h29,8'h29,1));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 0,32'h1008,     8'h29,8'h29,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h03,8'h00,8'h00, 0,32'h1008,     8'h29,8'h29,1));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 0,32'h1008,     8'h29,8'h29,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h03,8'h20,8'h00, 5,32'h2008,     8'h29,8'h29,1));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 0,32'h1008,     8'h29,8'h29,0));
    tbl.push_back(mk(1,2,32'h40,       0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 2,32'h40,       8'h2D,8'h2D,0));
    tbl.push_back(mk(0,0,0,            0,0, 1,2,32'h203, 1,2,32'h80,  8'h04,8'h00,8'h00, 2,32'h200,      8'h2D,8'h2D,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       1,2,32'h81,  8'h04,8'h00,8'h00, 2,32'h80,       8'h2D,8'h2D,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h00,8'h04,8'h00, 2,32'h84,       8'h2D,8'h2D,0));
    tbl.push_back(mk(0,0,0,            1,3, 0,0,0,       0,0,0,       8'h08,8'h00,8'h00, 3,32'h10C,      8'h25,8'h25,0));
    tbl.push_back(mk(0,0,0,            0,0, 1,3,32'h500, 0,0,0,       8'h08,8'h00,8'h00, 3,32'h10C,      8'h25,8'h25,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       1,3,32'h600, 8'h00,8'h00,8'h00, 3,32'h10C,      8'h25,8'h25,0));
    tbl.push_back(mk(1,3,32'h300,      1,3, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 3,32'h300,      8'h2D,8'h2D,0));
    tbl.push_back(mk(1,7,32'hFFFFFFFC, 0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 7,32'hFFFFFFFC, 8'hAD,8'hAD,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h80,8'h00,8'h00, 7,32'h0,        8'hAD,8'hAD,0));
    tbl.push_back(mk(0,0,0,            1,0, 0,0,0,       0,0,0,       8'h00,8'h01,8'h00, 0,32'h1008,     8'hAC,8'hAC,0));
    tbl.push_back(mk(1,4,32'h444,      0,0, 1,2,32'h900, 0,0,0,       8'h80,8'h00,8'h00, 2,32'h900,      8'hBC,8'hBC,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 7,32'h4,        8'hBC,8'hBC,0));
    tbl.push_back(mk(0,0,0,            0,0, 0,0,0,       0,0,0,       8'h00,8'h00,8'h00, 4,32'h444,      8'hBC,8'hBC,0));

    // Power-on reset for two cycles with random side inputs.
    rv = mk(1,3'($urandom),$urandom, 1,3'($urandom), 1,3'($urandom),$urandom,
            1,3'($urandom),$urandom, 8'h03,8'h81,8'($urandom), 0,0,0,0,0);
    rv.rst = 1'b1;
    drive(rv);
    IB_Full = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_all_reset("por");

    // Table-driven sequence: drive at negedge, sample 1 time unit after the next posedge.
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc%0d", i, tbl[i].cw), pc_of(tbl[i].cw), tbl[i].epc);
      check($sformatf("v%0d_valid", i), {24'h0, PC_Valid},  {24'h0, tbl[i].ev});
      check($sformatf("v%0d_freq", i),  {24'h0, Fetch_Req}, {24'h0, tbl[i].efr});
      check($sformatf("v%0d_err", i),   {31'h0, Err_Grant}, {31'h0, tbl[i].eerr});
    end

    // Mid-stream reset: it must override an init and an illegal grant in the same cycle.
    @(negedge clk);
    rv = mk(1,1,32'h44, 0,0, 1,2,32'h700, 0,0,0, 8'h03,8'h00,8'h00, 0,0,0,0,0);
    rv.rst = 1'b1;
    drive(rv);
    @(posedge clk);
    #1;
    check_all_reset("mid");

    // After reset is released, an idle cycle must leave the reset values in place.
    @(negedge clk);
    drive(mk(0,0,0, 0,0, 0,0,0, 0,0,0, 8'h00,8'h00,8'h00, 0,0,0,0,0));
    @(posedge clk);
    #1;
    check("post_pc1",   pc_of(1), 32'h0);
    check("post_valid", {24'h0, PC_Valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
